// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   Slice-sequential ALU. A WIDTH-bit operation is processed SLICE bits per
//   clock, least-significant slice first. Each slice adds with a flat carry
//   lookahead, and a registered carry links one slice to the next.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous, active-high
//   start     in   request, sampled only while not busy (IDLE or DONE)
//   ALUop     in   3  000 AND, 001 OR, 010 XOR, 011 NOR,
//                     100 SLT, 101 ADD, 110 SUB, 111 ADD
//   a, b      in   WIDTH operands, latched on the accepted start
//   busy      out  high while the operation is running
//   done      out  one-cycle pulse, result and flags valid
//   result    out  WIDTH registered result
//   zero      out  result == 0, updated on the final slice
//   overflow  out  signed overflow for ADD/SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // Slice datapath
    logic [SLICE-1:0] a_s, b_s, bp_s, g_s, p_s, sum_s, logic_s, slice_val;
    logic [SLICE:0]   c_s;
    logic             is_sub, is_arith, is_last, ovf_s, less_s, accept;

    // SUB and SLT both subtract: invert b and inject a carry of 1.
    assign is_sub   = op_q[2] & ~op_q[0];
    // Only ADD (101, 111) and SUB (110) report overflow.
    assign is_arith = op_q[2] & (op_q[0] | op_q[1]);
    assign is_last  = (idx_q == LAST_IDX);
    assign accept   = start & (state_q != S_RUN);

    always_comb begin : slice_select
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_s = a_q[i*SLICE +: SLICE];
                b_s = b_q[i*SLICE +: SLICE];
            end
        end
    end

    assign c_s[0] = carry_q;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            logic cout;

            assign bp_s[gi]  = b_s[gi] ^ is_sub;
            assign g_s[gi]   = a_s[gi] & bp_s[gi];
            assign p_s[gi]   = a_s[gi] | bp_s[gi];
            assign sum_s[gi] = a_s[gi] ^ bp_s[gi] ^ c_s[gi];

            // Flat lookahead: c[gi+1] = g[gi] | p[gi]g[gi-1] | ... | p[gi..0]c[0]
            always_comb begin : cla
                logic prod;
                cout = g_s[gi];
                prod = p_s[gi];
                for (int j = gi - 1; j >= 0; j--) begin
                    cout = cout | (prod & g_s[j]);
                    prod = prod & p_s[j];
                end
                cout = cout | (prod & c_s[0]);
            end

            assign c_s[gi+1] = cout;
        end
    endgenerate

    always_comb begin : logic_ops
        case (op_q[1:0])
            2'b00:   logic_s = a_s & b_s;
            2'b01:   logic_s = a_s | b_s;
            2'b10:   logic_s = a_s ^ b_s;
            default: logic_s = ~(a_s | b_s);
        endcase
    end

    assign slice_val = op_q[2] ? sum_s : logic_s;

    // Only meaningful on the most-significant slice.
    assign ovf_s  = (a_s[SLICE-1] == bp_s[SLICE-1]) & (sum_s[SLICE-1] != a_s[SLICE-1]);
    assign less_s = sum_s[SLICE-1] ^ ovf_s;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (is_last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin : datapath
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            op_d    = ALUop;
            idx_d   = '0;
            carry_d = ALUop[2] & ~ALUop[0];
        end else if (state_q == S_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    result_d[i*SLICE +: SLICE] = slice_val;
                end
            end
            carry_d = c_s[SLICE];
            idx_d   = idx_q + 1'b1;
            if (is_last) begin
                idx_d = '0;
                if (op_q == 3'b100) begin
                    result_d = {{(WIDTH-1){1'b0}}, less_s};
                end
                zero_d = (result_d == '0);
                ovf_d  = is_arith & ovf_s;
            end
        end
    end

    // Outputs
    always_comb begin : outputs
        busy     = (state_q == S_RUN);
        done     = (state_q == S_DONE);
        result   = result_q;
        zero     = zero_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, zero, overflow;
    logic [WIDTH-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_exp;

    alu_multicycle #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ALUop    (ALUop),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the whole word.
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic v);
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s  = 0;
        v  = 1'b0;
        case (op)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: r = x ^ y;
            3'b011: r = ~(x | y);
            3'b100: r = (sx < sy) ? 32'd1 : 32'd0;
            3'b110: begin
                s = sx - sy;
                r = s[31:0];
                v = (s != longint'($signed(r)));
            end
            default: begin
                s = sx + sy;
                r = s[31:0];
                v = (s != longint'($signed(r)));
            end
        endcase
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns at the
    // negedge where done is observed (DUT in DONE).
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb, input string tag);
        logic [31:0] er;
        logic        ev;
        int          cnt;
        model(op, x, y, er, ev);
        last_exp = er;
        ALUop = op;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!done && cnt < 3 * N) begin
            if (disturb) begin
                a     = $urandom;
                b     = $urandom;
                ALUop = 3'($urandom);
                start = 1'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cnt), 32'(N));
        check({tag, "_result"}, result, er);
        check({tag, "_zero"}, 32'(zero), 32'(er == 32'd0));
        check({tag, "_ovf"}, 32'(overflow), 32'(ev));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        $display("[TB] %s op=%03b a=0x%08h b=0x%08h -> result=0x%08h zero=%0b ovf=%0b cycles=%0d",
                 tag, op, x, y, result, zero, overflow, cnt);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_hold"}, result, last_exp);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        start = 1'b1;
        ALUop = 3'b101;
        a     = 32'h1234_5678;
        b     = 32'h0000_0001;

        // Reset has priority over start
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_nostart", 32'(busy), 32'd0);
        $display("[TB] reset with start held: outputs cleared, no operation started");

        // Directed cases
        run_op(3'b101, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, "add_chain");
        idle_cycle("add_chain");
        run_op(3'b110, 32'h8000_0000, 32'h0000_0001, 1'b0, "sub_ovf");
        idle_cycle("sub_ovf");
        run_op(3'b110, 32'h1234_5678, 32'h1234_5678, 1'b0, "sub_zero");
        idle_cycle("sub_zero");
        run_op(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "slt_neg");
        idle_cycle("slt_neg");
        run_op(3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "slt_pos");
        idle_cycle("slt_pos");

        // Logic ops, back-to-back, with start pulses and input churn during RUN
        run_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, "and");
        run_op(3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, "or");
        run_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, "xor");
        run_op(3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, "nor");
        idle_cycle("nor");

        // Reset mid-operation
        ALUop = 3'b101;
        a     = 32'h0F0F_0F0F;
        b     = 32'h1111_1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        $display("[TB] reset mid-RUN: operation aborted, done pulses seen=%0d", seen);
        last_exp = 32'd0;
        run_op(3'b101, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "after_abort");
        idle_cycle("after_abort");

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] x, y;
            op = 3'($urandom);
            x  = $urandom;
            y  = ($urandom_range(0, 7) == 0) ? x : $urandom;
            run_op(op, x, y, 1'($urandom), "rand");
            if ($urandom_range(0, 1) == 0) idle_cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
